// File: rtl/ysyx_220066_exu_pkg.sv
// ysyx_220066_exu_pkg
//   Shared core package for the execute stage. It holds the default
//   datapath width, the ALU control encoding used by id_aluctr/ex path,
//   the operand source encodings and a helper for forwarding matches.
//   No ports; imported by ysyx_220066_exu and ysyx_220066_ALU.
package ysyx_220066_exu_pkg;

  localparam int XLEN = 64;

  // aluctr[2:0] selects the basic operation
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SLL   = 3'd1,
    ALU_SLT   = 3'd2,
    ALU_PASSB = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SR    = 3'd5,
    ALU_OR    = 3'd6,
    ALU_AND   = 3'd7
  } alu_op_e;

  // aluctr[3] turns add into sub, slt into signed compare, srl into sra.
  // aluctr[4] marks a 32-bit word operation.
  localparam int ALUCTR_MOD_BIT  = 3;
  localparam int ALUCTR_WORD_BIT = 4;

  // Operand source selects
  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // A later stage's write matches a source register when it writes,
  // the indices agree, and the register is not x0 (x0 is never forwarded).
  function automatic logic fwd_hit(input logic       wen,
                                   input logic [4:0] fwd_rd,
                                   input logic [4:0] rs);
    return wen && (fwd_rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/ysyx_220066_exu_alu.sv
// ysyx_220066_ALU
//   Purely combinational integer ALU for the execute stage.
//   Ports:
//     a, b    : operands (XLEN)
//     op      : basic operation (aluctr[2:0])
//     modify  : sub / signed compare / arithmetic shift (aluctr[3])
//     word    : 32-bit operation (aluctr[4]); only affects right shifts here,
//               the caller handles result sign-extension and shamt masking
//     result  : operation result (XLEN)
//     zero    : adder output is zero
module ysyx_220066_ALU #(
  parameter int XLEN = ysyx_220066_exu_pkg::XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  input  logic            modify,
  input  logic            word,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import ysyx_220066_exu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic            adder_sub;
  logic [XLEN-1:0] adder_b;
  logic [XLEN-1:0] sum;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sr_src;
  logic            less;

  // The adder subtracts for sub and for compares, so the zero flag
  // reports a == b for branch comparisons.
  assign adder_sub = ((op == ALU_ADD) && modify) || (op == ALU_SLT);
  assign adder_b   = adder_sub ? ~b : b;
  assign sum       = a + adder_b + {{(XLEN-1){1'b0}}, adder_sub};
  assign zero      = (sum == '0);
  assign shamt     = b[SHW-1:0];

  // Word right shifts must only see the low 32 bits of a, extended the
  // way the shift itself extends (zero for srlw, sign for sraw).
  always_comb begin
    sr_src = a;
    if (word) begin
      sr_src = modify ? {{(XLEN-32){a[31]}}, a[31:0]}
                      : {{(XLEN-32){1'b0}},  a[31:0]};
    end
  end

  assign less = modify ? ($signed(a) < $signed(b)) : (a < b);

  // Operation select
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:   result = sum;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, less};
      ALU_PASSB: result = b;
      ALU_XOR:   result = a ^ b;
      ALU_SR:    result = modify ? $unsigned($signed(sr_src) >>> shamt)
                                 : (sr_src >> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_exu.sv
// ysyx_220066_exu
//   Execute stage: one-entry ID/EX register with valid/ready handshakes,
//   MEM/WB forwarding onto the held instruction, and the ALU.
//   Ports:
//     clk, rst                       : clock, async active-high reset
//     id_valid / id_ready            : decode-side handshake
//     id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
//     id_wen, id_aluctr, id_src_a, id_src_b : decode payload
//     flush                          : kills held and incoming instruction
//     mem_fwd_*, wb_fwd_*            : forwarding sources (wen, rd, data)
//     ex_valid / ex_ready            : MEM-side handshake
//     ex_result, ex_zero, ex_rd, ex_wen, ex_pc, ex_store_data : EX outputs
module ysyx_220066_exu #(
  parameter int XLEN = ysyx_220066_exu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_wen,
  input  logic [4:0]      id_aluctr,
  input  logic            id_src_a,
  input  logic            id_src_b,
  input  logic            flush,
  input  logic            mem_fwd_wen,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_wen,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_result,
  output logic            ex_zero,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data
);
  import ysyx_220066_exu_pkg::*;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic [4:0]      aluctr_q;
  logic            src_a_q;
  logic            src_b_q;

  logic            load;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            is_word;
  logic            is_word_shift;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  assign id_ready = ~valid_q | ex_ready;
  assign load     = id_valid & id_ready & ~flush;

  // ID/EX register. Flush beats load and drain; a stalled instruction
  // keeps its payload because nothing is written unless we load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      aluctr_q   <= '0;
      src_a_q    <= 1'b0;
      src_b_q    <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (valid_q && ex_ready) begin
        valid_q <= 1'b0;
      end
      if (load) begin
        pc_q       <= id_pc;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rd_q       <= id_rd;
        wen_q      <= id_wen;
        aluctr_q   <= id_aluctr;
        src_a_q    <= id_src_a;
        src_b_q    <= id_src_b;
      end
    end
  end

  // Forwarding runs on the registered indices every cycle, so a stalled
  // instruction still sees producers that complete while it waits.
  // MEM is younger than WB and therefore wins.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (fwd_hit(mem_fwd_wen, mem_fwd_rd, rs1_q)) begin
      rs1_fwd = mem_fwd_data;
    end else if (fwd_hit(wb_fwd_wen, wb_fwd_rd, rs1_q)) begin
      rs1_fwd = wb_fwd_data;
    end
    rs2_fwd = rs2_data_q;
    if (fwd_hit(mem_fwd_wen, mem_fwd_rd, rs2_q)) begin
      rs2_fwd = mem_fwd_data;
    end else if (fwd_hit(wb_fwd_wen, wb_fwd_rd, rs2_q)) begin
      rs2_fwd = wb_fwd_data;
    end
  end

  assign is_word       = aluctr_q[ALUCTR_WORD_BIT];
  assign is_word_shift = is_word &&
                         ((aluctr_q[2:0] == ALU_SLL) || (aluctr_q[2:0] == ALU_SR));

  // Operand select; word shifts only use a 5-bit shift amount
  always_comb begin
    op_a = (src_a_q == SRC_A_PC)  ? pc_q  : rs1_fwd;
    op_b = (src_b_q == SRC_B_IMM) ? imm_q : rs2_fwd;
    if (is_word_shift) begin
      op_b[5] = 1'b0;
    end
  end

  ysyx_220066_ALU #(
    .XLEN(XLEN)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (aluctr_q[2:0]),
    .modify (aluctr_q[ALUCTR_MOD_BIT]),
    .word   (is_word),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign ex_valid      = valid_q;
  assign ex_result     = is_word ? {{(XLEN-32){alu_result[31]}}, alu_result[31:0]}
                                 : alu_result;
  assign ex_zero       = alu_zero;
  assign ex_rd         = rd_q;
  assign ex_wen        = wen_q;
  assign ex_pc         = pc_q;
  assign ex_store_data = rs2_fwd;

endmodule
